// File: rtl/rob_commit_unit_pkg.sv
// ----------------------------------------------------------------------------
// rob_commit_unit_pkg
// Shared types for the reorder buffer and its rename-side channel:
//   - ROB geometry (DEPTH entries, IDX_W index bits)
//   - rob_idx_t / rob_ptr_t (pointer carries an extra wrap bit)
//   - arch_addr_t / phy_addr_t register address types
//   - rob_entry_t per-entry payload, rob_state_e retirement state
// Optional feature macro: ROB_COMMIT_TRACE_EN (adds the PC field to entries).
// ----------------------------------------------------------------------------
package rob_commit_unit_pkg;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef logic [IDX_W-1:0] rob_idx_t;
  typedef logic [IDX_W:0]   rob_ptr_t;
  typedef logic [4:0]       arch_addr_t;
  typedef logic [5:0]       phy_addr_t;
  typedef logic [31:0]      addr_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rob_state_e;

  typedef struct packed {
    logic       valid;
    logic       done;
    logic       redirect;
    arch_addr_t rd_arch;
    phy_addr_t  rd_phy;
    phy_addr_t  rd_origin;
`ifdef ROB_COMMIT_TRACE_EN
    addr_t      pc;
`endif
    addr_t      redirect_pc;
  } rob_entry_t;

  // Entry index part of a wrap-bit pointer.
  function automatic rob_idx_t ptr_idx(input rob_ptr_t p);
    return p[IDX_W-1:0];
  endfunction

  // Wrap bit of a pointer.
  function automatic logic ptr_wrap(input rob_ptr_t p);
    return p[IDX_W];
  endfunction

endpackage

// File: rtl/rob_commit_unit_if.sv
// ----------------------------------------------------------------------------
// rob_commit_unit_if
// Rename <-> ROB channel: dispatch, writeback completion, commit/free and
// pipeline flush.
//   master : rename/writeback side (drives disp_*, wb_*)
//   slave  : ROB side (drives disp_ready, disp_idx, free_valid, rd_*, flush*)
// ----------------------------------------------------------------------------
interface rob_commit_unit_if
  import rob_commit_unit_pkg::*;
();

  // Dispatch
  logic       disp_valid;
  logic       disp_ready;
  arch_addr_t disp_rd_arch;
  phy_addr_t  disp_rd_phy;
  phy_addr_t  disp_rd_origin;
  addr_t      disp_pc;
  rob_idx_t   disp_idx;

  // Writeback
  logic       wb_valid;
  rob_idx_t   wb_idx;
  logic       wb_redirect;
  addr_t      wb_redirect_pc;

  // Commit / free
  logic       free_valid;
  arch_addr_t rd_arch;
  phy_addr_t  rd_phy;
  phy_addr_t  rd_origin;

  // Flush
  logic       flush;
  addr_t      flush_pc;

  modport master (
    output disp_valid, disp_rd_arch, disp_rd_phy, disp_rd_origin, disp_pc,
    input  disp_ready, disp_idx,
    output wb_valid, wb_idx, wb_redirect, wb_redirect_pc,
    input  free_valid, rd_arch, rd_phy, rd_origin,
    input  flush, flush_pc
  );

  modport slave (
    input  disp_valid, disp_rd_arch, disp_rd_phy, disp_rd_origin, disp_pc,
    output disp_ready, disp_idx,
    input  wb_valid, wb_idx, wb_redirect, wb_redirect_pc,
    output free_valid, rd_arch, rd_phy, rd_origin,
    output flush, flush_pc
  );

endinterface

// File: rtl/rob_commit_unit.sv
// ----------------------------------------------------------------------------
// rob_commit_unit
// In-order retirement stage: circular reorder buffer that allocates one entry
// per dispatched instruction, marks entries done on writeback, retires at most
// one entry per cycle and raises a one-cycle flush after a redirecting entry
// retires.
// Ports:
//   clk      : clock
//   rst      : synchronous, active-high reset
//   rob_if   : rob_commit_unit_if.slave (dispatch / writeback / free / flush)
// Optional feature macro ROB_COMMIT_TRACE_EN:
//   debug_commit_valid_o / debug_commit_pc_o / debug_commit_rd_o, registered
//   one cycle after free_valid, plus a checker on writeback to invalid entries.
// ----------------------------------------------------------------------------
module rob_commit_unit
  import rob_commit_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  rob_commit_unit_if.slave  rob_if
`ifdef ROB_COMMIT_TRACE_EN
  ,
  output logic              debug_commit_valid_o,
  output addr_t             debug_commit_pc_o,
  output arch_addr_t        debug_commit_rd_o
`endif
);

  rob_entry_t entries_q [DEPTH];
  rob_ptr_t   head_q, head_d;
  rob_ptr_t   tail_q, tail_d;
  rob_state_e state_q, state_d;
  addr_t      flush_pc_q, flush_pc_d;

  rob_entry_t head_entry_s;
  rob_entry_t new_entry_s;
  logic       full_s;
  logic       disp_ready_s;
  logic       disp_fire_s;
  logic       commit_s;
  logic       commit_redirect_s;
  logic       wb_hit_s;

  // Head entry view and the handshake qualifiers derived from it.
  always_comb begin
    head_entry_s      = entries_q[ptr_idx(head_q)];
    // Same index with opposite wrap bits means the tail lapped the head.
    full_s            = (ptr_idx(head_q) == ptr_idx(tail_q)) &&
                        (ptr_wrap(head_q) != ptr_wrap(tail_q));
    disp_ready_s      = ~full_s & (state_q == RUN);
    disp_fire_s       = rob_if.disp_valid & disp_ready_s;
    commit_s          = (state_q == RUN) & head_entry_s.valid & head_entry_s.done;
    commit_redirect_s = commit_s & head_entry_s.redirect;
    wb_hit_s          = rob_if.wb_valid & (state_q == RUN) &
                        entries_q[rob_if.wb_idx].valid;
  end

  // Payload written into the tail entry on dispatch.
  always_comb begin
    new_entry_s           = '0;
    new_entry_s.valid     = 1'b1;
    new_entry_s.done      = 1'b0;
    new_entry_s.redirect  = 1'b0;
    new_entry_s.rd_arch   = rob_if.disp_rd_arch;
    new_entry_s.rd_phy    = rob_if.disp_rd_phy;
    new_entry_s.rd_origin = rob_if.disp_rd_origin;
`ifdef ROB_COMMIT_TRACE_EN
    new_entry_s.pc        = rob_if.disp_pc;
`endif
  end

`ifndef ROB_COMMIT_TRACE_EN
  // The PC is only kept for the commit trace.
  logic unused_disp_pc_s;
  assign unused_disp_pc_s = ^rob_if.disp_pc;
`endif

  // Entry array: dispatch write, writeback completion, commit release.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else if (state_q == FLUSH) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else begin
      if (disp_fire_s) begin
        entries_q[ptr_idx(tail_q)] <= new_entry_s;
      end
      if (wb_hit_s) begin
        entries_q[rob_if.wb_idx].done        <= 1'b1;
        entries_q[rob_if.wb_idx].redirect    <= rob_if.wb_redirect;
        entries_q[rob_if.wb_idx].redirect_pc <= rob_if.wb_redirect_pc;
      end
      // Placed last so a retiring head always leaves invalid.
      if (commit_s) begin
        entries_q[ptr_idx(head_q)].valid <= 1'b0;
      end
    end
  end

  // Next head/tail pointers and flush target.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    flush_pc_d = flush_pc_q;
    if (state_q == FLUSH) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (disp_fire_s) begin
        tail_d = tail_q + rob_ptr_t'(1);
      end else begin
        tail_d = tail_q;
      end
      if (commit_s) begin
        head_d = head_q + rob_ptr_t'(1);
      end else begin
        head_d = head_q;
      end
      if (commit_redirect_s) begin
        flush_pc_d = head_entry_s.redirect_pc;
      end else begin
        flush_pc_d = flush_pc_q;
      end
    end
  end

  // Pointer and flush-target registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      flush_pc_q <= 32'h0000_0000;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: FLUSH always lasts a single cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (commit_redirect_s) begin
          state_d = FLUSH;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM / channel outputs; retiring rd fields read zero when nothing retires.
  always_comb begin
    rob_if.disp_ready = disp_ready_s;
    rob_if.disp_idx   = ptr_idx(tail_q);
    rob_if.free_valid = commit_s;
    if (commit_s) begin
      rob_if.rd_arch   = head_entry_s.rd_arch;
      rob_if.rd_phy    = head_entry_s.rd_phy;
      rob_if.rd_origin = head_entry_s.rd_origin;
    end else begin
      rob_if.rd_arch   = 5'd0;
      rob_if.rd_phy    = 6'd0;
      rob_if.rd_origin = 6'd0;
    end
    rob_if.flush    = (state_q == FLUSH);
    rob_if.flush_pc = flush_pc_q;
  end

`ifdef ROB_COMMIT_TRACE_EN
  logic       dbg_valid_q;
  addr_t      dbg_pc_q;
  arch_addr_t dbg_rd_q;

  // Commit trace, delayed one cycle behind free_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_valid_q <= 1'b0;
      dbg_pc_q    <= 32'h0000_0000;
      dbg_rd_q    <= 5'd0;
    end else begin
      dbg_valid_q <= commit_s;
      dbg_pc_q    <= head_entry_s.pc;
      dbg_rd_q    <= head_entry_s.rd_arch;
    end
  end

  assign debug_commit_valid_o = dbg_valid_q;
  assign debug_commit_pc_o    = dbg_pc_q;
  assign debug_commit_rd_o    = dbg_rd_q;

  rob_commit_unit_chk u_chk (
    .clk_i             (clk),
    .rst_i             (rst),
    .wb_valid_i        (rob_if.wb_valid & (state_q == RUN)),
    .wb_target_valid_i (entries_q[rob_if.wb_idx].valid)
  );
`endif

endmodule

`ifdef ROB_COMMIT_TRACE_EN
// Checker: a completion report must target an allocated entry.
module rob_commit_unit_chk (
  input logic clk_i,
  input logic rst_i,
  input logic wb_valid_i,
  input logic wb_target_valid_i
);
  wb_to_invalid_entry_a: assert property (
    @(posedge clk_i) disable iff (rst_i) wb_valid_i |-> wb_target_valid_i
  );
endmodule
`endif
